// File: rtl/ex_operand_stage_pkg.sv
// ============================================================================
//  Module      : ex_operand_stage_pkg
//  Description : Shared constants and ALU op encodings for the ID/EX operand
//                stage. The optional ES_PERF_CNT_EN build is selected in the
//                top-level file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_operand_stage_pkg;

  localparam int ES_DATA_W = 32;
  localparam int ES_RA_W   = 5;

  // ALU op encodings shared with the ID decoder and the ALU.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLT  = 5'd2,
    ALU_SLTU = 5'd3,
    ALU_AND  = 5'd4,
    ALU_OR   = 5'd5,
    ALU_XOR  = 5'd6,
    ALU_NOR  = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/ex_operand_stage_if.sv
// ============================================================================
//  Module      : ex_operand_stage_if
//  Description : Bundles the ID handshake, MEM/WB bypass, ALU operand and
//                EX/MEM passthrough signals of the operand stage.
//                slave  = the stage itself, master = its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);
  logic              flush;
  // ID -> EX
  logic              ds_valid;
  logic              es_allowin;
  logic [31:0]       ds_pc;
  logic [4:0]        ds_alu_op;
  logic [RA_W-1:0]   ds_rj;
  logic [RA_W-1:0]   ds_rk;
  logic [DATA_W-1:0] ds_rj_val;
  logic [DATA_W-1:0] ds_rk_val;
  logic [DATA_W-1:0] ds_imm;
  logic              ds_src1_pc;
  logic              ds_src2_imm;
  logic              ds_rf_we;
  logic              ds_is_load;
  logic [RA_W-1:0]   ds_dest;
  // MEM / WB bypass sources
  logic              ms_we;
  logic [RA_W-1:0]   ms_dest;
  logic [DATA_W-1:0] ms_data;
  logic              ms_data_ok;
  logic              ws_we;
  logic [RA_W-1:0]   ws_dest;
  logic [DATA_W-1:0] ws_data;
  // ALU side
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_op;
  // EX -> MEM
  logic              es_valid_o;
  logic              ms_allowin;
  logic [31:0]       es_pc;
  logic [DATA_W-1:0] es_rkd;
  logic              es_rf_we;
  logic              es_is_load;
  logic [RA_W-1:0]   es_dest;

  modport slave (
    input  flush, ds_valid, ds_pc, ds_alu_op, ds_rj, ds_rk, ds_rj_val, ds_rk_val,
           ds_imm, ds_src1_pc, ds_src2_imm, ds_rf_we, ds_is_load, ds_dest,
           ms_we, ms_dest, ms_data, ms_data_ok, ws_we, ws_dest, ws_data, ms_allowin,
    output es_allowin, alu_a, alu_b, alu_op, es_valid_o, es_pc, es_rkd,
           es_rf_we, es_is_load, es_dest
  );

  modport master (
    output flush, ds_valid, ds_pc, ds_alu_op, ds_rj, ds_rk, ds_rj_val, ds_rk_val,
           ds_imm, ds_src1_pc, ds_src2_imm, ds_rf_we, ds_is_load, ds_dest,
           ms_we, ms_dest, ms_data, ms_data_ok, ws_we, ws_dest, ws_data, ms_allowin,
    input  es_allowin, alu_a, alu_b, alu_op, es_valid_o, es_pc, es_rkd,
           es_rf_we, es_is_load, es_dest
  );
endinterface

`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
// ============================================================================
//  Module      : es_fwd_mux
//  Description : Per-source bypass selector. MEM wins over WB; register 0 is
//                never bypassed. Flags a MEM match whose data is not final.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module es_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  wire  [RA_W-1:0]   i_src,
  input  wire  [DATA_W-1:0] i_held,
  input  wire               i_ms_we,
  input  wire  [RA_W-1:0]   i_ms_dest,
  input  wire  [DATA_W-1:0] i_ms_data,
  input  wire               i_ms_data_ok,
  input  wire               i_ws_we,
  input  wire  [RA_W-1:0]   i_ws_dest,
  input  wire  [DATA_W-1:0] i_ws_data,
  output logic [DATA_W-1:0] o_val,
  output logic              o_mem_hit_pending,
  output logic              o_hit
);

  logic w_src_nz;
  logic w_ms_hit;
  logic w_ws_hit;

  assign w_src_nz = |i_src;
  assign w_ms_hit = w_src_nz && i_ms_we && (i_ms_dest == i_src);
  assign w_ws_hit = w_src_nz && i_ws_we && (i_ws_dest == i_src);

  // Select the youngest producer: MEM, then WB, then the held value.
  always_comb begin
    o_val = i_held;
    if (w_ms_hit) begin
      o_val = i_ms_data;
    end else if (w_ws_hit) begin
      o_val = i_ws_data;
    end
  end

  assign o_mem_hit_pending = w_ms_hit && !i_ms_data_ok;
  assign o_hit             = w_ms_hit || w_ws_hit;

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
//  Module      : ex_operand_stage
//  Description : ID/EX pipeline register in front of the integer ALU. Holds
//                one decoded instruction, bypasses rj/rk from MEM/WB, stalls
//                on load-use and keeps held operands fresh while stalled.
//                Define ES_PERF_CNT_EN to add stall_cnt/fwd_cnt counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = ES_DATA_W,
  parameter int RA_W   = ES_RA_W
) (
  input  wire               clk,
  input  wire               reset,
  ex_operand_stage_if.slave bus
`ifdef ES_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [4:0]        r_alu_op;
  logic [RA_W-1:0]   r_rj;
  logic [RA_W-1:0]   r_rk;
  logic [DATA_W-1:0] r_rj_val;
  logic [DATA_W-1:0] r_rk_val;
  logic [DATA_W-1:0] r_imm;
  logic              r_src1_pc;
  logic              r_src2_imm;
  logic              r_rf_we;
  logic              r_is_load;
  logic [RA_W-1:0]   r_dest;

  logic [DATA_W-1:0] w_rj_fwd;
  logic [DATA_W-1:0] w_rk_fwd;
  logic              w_rj_pend;
  logic              w_rk_pend;
  logic              w_rj_hit;
  logic              w_rk_hit;
  logic              w_load_use;
  logic              w_ready_go;
  logic              w_valid_o;
  logic              w_allowin;
  logic              w_accept;
  logic              w_leave;
  logic              w_used_hit;

  es_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rj (
    .i_src             (r_rj),
    .i_held            (r_rj_val),
    .i_ms_we           (bus.ms_we),
    .i_ms_dest         (bus.ms_dest),
    .i_ms_data         (bus.ms_data),
    .i_ms_data_ok      (bus.ms_data_ok),
    .i_ws_we           (bus.ws_we),
    .i_ws_dest         (bus.ws_dest),
    .i_ws_data         (bus.ws_data),
    .o_val             (w_rj_fwd),
    .o_mem_hit_pending (w_rj_pend),
    .o_hit             (w_rj_hit)
  );

  es_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rk (
    .i_src             (r_rk),
    .i_held            (r_rk_val),
    .i_ms_we           (bus.ms_we),
    .i_ms_dest         (bus.ms_dest),
    .i_ms_data         (bus.ms_data),
    .i_ms_data_ok      (bus.ms_data_ok),
    .i_ws_we           (bus.ws_we),
    .i_ws_dest         (bus.ws_dest),
    .i_ws_data         (bus.ws_data),
    .o_val             (w_rk_fwd),
    .o_mem_hit_pending (w_rk_pend),
    .o_hit             (w_rk_hit)
  );

  // rj only matters when it feeds operand A; rk is always consumed (store data).
  assign w_load_use = r_valid && ((!r_src1_pc && w_rj_pend) || w_rk_pend);
  assign w_ready_go = !w_load_use;
  assign w_allowin  = !r_valid || (w_ready_go && bus.ms_allowin);
  assign w_valid_o  = r_valid && w_ready_go && !bus.flush;
  assign w_accept   = bus.ds_valid && w_allowin;
  assign w_leave    = w_valid_o && bus.ms_allowin;
  assign w_used_hit = (!r_src1_pc && w_rj_hit) || w_rk_hit;

  // Pipeline register: flush beats accept, accept beats leave, otherwise
  // refresh held operands so a producer retiring past WB is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_alu_op   <= '0;
      r_rj       <= '0;
      r_rk       <= '0;
      r_rj_val   <= '0;
      r_rk_val   <= '0;
      r_imm      <= '0;
      r_src1_pc  <= 1'b0;
      r_src2_imm <= 1'b0;
      r_rf_we    <= 1'b0;
      r_is_load  <= 1'b0;
      r_dest     <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= bus.ds_pc;
      r_alu_op   <= bus.ds_alu_op;
      r_rj       <= bus.ds_rj;
      r_rk       <= bus.ds_rk;
      r_rj_val   <= bus.ds_rj_val;
      r_rk_val   <= bus.ds_rk_val;
      r_imm      <= bus.ds_imm;
      r_src1_pc  <= bus.ds_src1_pc;
      r_src2_imm <= bus.ds_src2_imm;
      r_rf_we    <= bus.ds_rf_we;
      r_is_load  <= bus.ds_is_load;
      r_dest     <= bus.ds_dest;
    end else if (w_leave) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_rj_val <= w_rj_fwd;
      r_rk_val <= w_rk_fwd;
    end
  end

  assign bus.es_allowin = w_allowin;
  assign bus.es_valid_o = w_valid_o;
  assign bus.alu_a      = r_src1_pc  ? r_pc  : w_rj_fwd;
  assign bus.alu_b      = r_src2_imm ? r_imm : w_rk_fwd;
  assign bus.alu_op     = r_alu_op;
  assign bus.es_pc      = r_pc;
  assign bus.es_rkd     = w_rk_fwd;
  assign bus.es_rf_we   = r_rf_we;
  assign bus.es_is_load = r_is_load;
  assign bus.es_dest    = r_dest;

`ifdef ES_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  // Free-running event counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_load_use) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_leave && w_used_hit) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  logic w_unused_hit;
  assign w_unused_hit = w_used_hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// ============================================================================
//  Module      : tb_ex_operand_stage
//  Description : Self-checking bench for ex_operand_stage. Expected EX/MEM
//                transfers are queued when an instruction is driven and
//                compared when the stage hands it downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk;
  logic reset;

  ex_operand_stage_if #(.DATA_W(32), .RA_W(5)) bus ();

`ifdef ES_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ES_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rkd;
    logic [4:0]  op;
    logic [4:0]  dest;
    logic        we;
    logic        ld;
    logic        fwd;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;
  int   exp_stall;
  int   exp_fwd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_ins(input logic [31:0] pc, input logic [4:0] op,
                           input logic [4:0] rj, input logic [4:0] rk,
                           input logic [31:0] rjv, input logic [31:0] rkv,
                           input logic [31:0] imm, input logic s1pc, input logic s2imm,
                           input logic we, input logic ld, input logic [4:0] dest);
    bus.ds_valid    = 1'b1;
    bus.ds_pc       = pc;
    bus.ds_alu_op   = op;
    bus.ds_rj       = rj;
    bus.ds_rk       = rk;
    bus.ds_rj_val   = rjv;
    bus.ds_rk_val   = rkv;
    bus.ds_imm      = imm;
    bus.ds_src1_pc  = s1pc;
    bus.ds_src2_imm = s2imm;
    bus.ds_rf_we    = we;
    bus.ds_is_load  = ld;
    bus.ds_dest     = dest;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rkd, input logic [4:0] op, input logic [4:0] dest,
                          input logic we, input logic ld, input logic fwd);
    exp_t e;
    e.pc = pc; e.a = a; e.b = b; e.rkd = rkd; e.op = op;
    e.dest = dest; e.we = we; e.ld = ld; e.fwd = fwd;
    sb.push_back(e);
  endtask

  // Downstream monitor: every transfer into MEM is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.es_valid_o && bus.ms_allowin) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_pc",   bus.es_pc,      e.pc);
        chk("out_a",    bus.alu_a,      e.a);
        chk("out_b",    bus.alu_b,      e.b);
        chk("out_rkd",  bus.es_rkd,     e.rkd);
        chk("out_op",   bus.alu_op,     e.op);
        chk("out_dest", bus.es_dest,    e.dest);
        chk("out_we",   bus.es_rf_we,   e.we);
        chk("out_ld",   bus.es_is_load, e.ld);
        if (e.fwd) exp_fwd++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t_rjv [4];
    logic [31:0] t_rkv [4];
    logic [31:0] t_imm [4];
    logic        t_s1  [4];
    logic        t_s2  [4];
    logic [4:0]  t_op  [4];
    logic [31:0] t_a, t_b, t_pc;

    n_chk = 0; n_pass = 0; exp_stall = 0; exp_fwd = 0;
    reset = 1'b1;
    bus.flush = 1'b0; bus.ds_valid = 1'b0; bus.ds_pc = '0; bus.ds_alu_op = '0;
    bus.ds_rj = '0; bus.ds_rk = '0; bus.ds_rj_val = '0; bus.ds_rk_val = '0;
    bus.ds_imm = '0; bus.ds_src1_pc = 1'b0; bus.ds_src2_imm = 1'b0;
    bus.ds_rf_we = 1'b0; bus.ds_is_load = 1'b0; bus.ds_dest = '0;
    bus.ms_we = 1'b0; bus.ms_dest = '0; bus.ms_data = '0; bus.ms_data_ok = 1'b1;
    bus.ws_we = 1'b0; bus.ws_dest = '0; bus.ws_data = '0; bus.ms_allowin = 1'b1;

    // Reset state
    cyc(); cyc();
    reset = 1'b0;
    mid();
    chk("rst_valid_o", bus.es_valid_o, 0);
    chk("rst_allowin", bus.es_allowin, 1);
    chk("rst_alu_a",   bus.alu_a, 0);
    chk("rst_alu_b",   bus.alu_b, 0);
    chk("rst_pc",      bus.es_pc, 0);
    chk("rst_dest",    bus.es_dest, 0);

    // Basic ADD with immediate, one-cycle latency
    cyc();
    drive_ins(32'h100, ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd0, 32'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3);
    push_exp(32'h100, 32'd5, 32'd7, 32'd0, ALU_ADD, 5'd3, 1'b1, 1'b0, 1'b0);
    mid();
    chk("t1_allowin", bus.es_allowin, 1);
    cyc();
    bus.ds_valid = 1'b0;
    mid();
    chk("t1_valid_o", bus.es_valid_o, 1);

    // MEM bypass beats WB bypass
    cyc();
    drive_ins(32'h200, ALU_SUB, 5'd3, 5'd0, 32'h1, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9);
    bus.ms_we = 1'b1; bus.ms_dest = 5'd3; bus.ms_data = 32'h10; bus.ms_data_ok = 1'b1;
    bus.ws_we = 1'b1; bus.ws_dest = 5'd3; bus.ws_data = 32'h20;
    push_exp(32'h200, 32'h10, 32'h77, 32'h77, ALU_SUB, 5'd9, 1'b1, 1'b0, 1'b1);
    mid();
    cyc();
    bus.ds_valid = 1'b0;
    mid();

    // Register 0 is never bypassed
    cyc();
    drive_ins(32'h300, ALU_AND, 5'd0, 5'd0, 32'h33, 32'h44, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    bus.ms_dest = 5'd0; bus.ms_data = 32'h44; bus.ws_we = 1'b0;
    push_exp(32'h300, 32'h33, 32'h8, 32'h44, ALU_AND, 5'd0, 1'b0, 1'b0, 1'b0);
    mid();
    cyc();
    bus.ds_valid = 1'b0;
    mid();

    // Load-use on rk: three stall cycles, then data arrives
    cyc();
    bus.ms_we = 1'b0;
    drive_ins(32'h340, ALU_OR, 5'd5, 5'd4, 32'h2, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
    bus.ms_we = 1'b1; bus.ms_dest = 5'd4; bus.ms_data = 32'hdead; bus.ms_data_ok = 1'b0;
    push_exp(32'h340, 32'h2, 32'h55, 32'h55, ALU_OR, 5'd6, 1'b0, 1'b1, 1'b1);
    mid();
    cyc();
    bus.ds_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("lu_valid_o", bus.es_valid_o, 0);
      chk("lu_allowin", bus.es_allowin, 0);
      exp_stall++;
      cyc();
    end
    bus.ms_data_ok = 1'b1; bus.ms_data = 32'h55;
    mid();
    chk("lu_release", bus.es_valid_o, 1);
    cyc();
    bus.ms_we = 1'b0;

    // Operand refresh while downstream is stalled
    drive_ins(32'h380, ALU_XOR, 5'd6, 5'd7, 32'h11, 32'h70, 32'h5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8);
    bus.ws_we = 1'b1; bus.ws_dest = 5'd6; bus.ws_data = 32'h99;
    bus.ms_allowin = 1'b0;
    push_exp(32'h380, 32'h99, 32'h5, 32'h70, ALU_XOR, 5'd8, 1'b1, 1'b0, 1'b0);
    mid();
    cyc();
    bus.ds_valid = 1'b0;
    mid();
    chk("rf_hold_valid", bus.es_valid_o, 1);
    chk("rf_hold_allowin", bus.es_allowin, 0);
    cyc();
    bus.ws_we = 1'b0;
    mid();
    chk("rf_refresh_a", bus.alu_a, 32'h99);
    cyc();
    bus.ms_allowin = 1'b1;
    mid();

    // Flush drops an incoming instruction
    cyc();
    drive_ins(32'h500, ALU_NOR, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1);
    bus.flush = 1'b1;
    mid();
    chk("fl_allowin", bus.es_allowin, 1);
    cyc();
    bus.ds_valid = 1'b0; bus.flush = 1'b0;
    mid();
    chk("fl_valid_o", bus.es_valid_o, 0);

    // Flush kills a held instruction
    cyc();
    drive_ins(32'h540, ALU_SLT, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
    bus.ms_allowin = 1'b0;
    mid();
    cyc();
    bus.ds_valid = 1'b0; bus.flush = 1'b1;
    mid();
    chk("flh_mask", bus.es_valid_o, 0);
    cyc();
    bus.flush = 1'b0; bus.ms_allowin = 1'b1;
    mid();
    chk("flh_gone", bus.es_valid_o, 0);
    chk("flh_allowin", bus.es_allowin, 1);

    // Back-to-back stream of four
    t_rjv = '{32'h10, 32'h0, 32'h1234, 32'hA5};
    t_rkv = '{32'h3, 32'h21, 32'h0ff0, 32'h9};
    t_imm = '{32'h0, 32'h0F, 32'h0, 32'h4};
    t_s1  = '{1'b0, 1'b1, 1'b0, 1'b0};
    t_s2  = '{1'b0, 1'b1, 1'b0, 1'b1};
    t_op  = '{ALU_SUB, ALU_OR, ALU_XOR, ALU_SLL};
    for (int i = 0; i < 4; i++) begin
      cyc();
      t_pc = 32'h400 + 32'(4 * i);
      drive_ins(t_pc, t_op[i], 5'd1, 5'd2, t_rjv[i], t_rkv[i], t_imm[i],
                t_s1[i], t_s2[i], 1'b1, 1'b0, 5'(10 + i));
      t_a = t_s1[i] ? t_pc : t_rjv[i];
      t_b = t_s2[i] ? t_imm[i] : t_rkv[i];
      push_exp(t_pc, t_a, t_b, t_rkv[i], t_op[i], 5'(10 + i), 1'b1, 1'b0, 1'b0);
      mid();
      chk("b2b_allowin", bus.es_allowin, 1);
      if (i > 0) chk("b2b_valid_o", bus.es_valid_o, 1);
    end
    cyc();
    bus.ds_valid = 1'b0;
    mid();
    chk("b2b_last", bus.es_valid_o, 1);
    cyc();
    mid();
    chk("b2b_drained", bus.es_valid_o, 0);

`ifdef ES_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 64'(exp_stall));
    chk("fwd_cnt",   fwd_cnt,   64'(exp_fwd));
`endif

    // Reset asserted during a load-use stall
    cyc();
    drive_ins(32'h600, ALU_SRA, 5'd1, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
    bus.ms_we = 1'b1; bus.ms_dest = 5'd4; bus.ms_data_ok = 1'b0;
    mid();
    cyc();
    bus.ds_valid = 1'b0;
    mid();
    chk("rs_stall", bus.es_valid_o, 0);
    cyc();
    reset = 1'b1;
    mid();
    cyc();
    reset = 1'b0; bus.ms_we = 1'b0; bus.ms_data_ok = 1'b1;
    mid();
    chk("rs_valid_o", bus.es_valid_o, 0);
    chk("rs_pc",      bus.es_pc, 0);
    chk("rs_alu_a",   bus.alu_a, 0);
    chk("rs_allowin", bus.es_allowin, 1);
`ifdef ES_PERF_CNT_EN
    chk("rs_stall_cnt", stall_cnt, 0);
    chk("rs_fwd_cnt",   fwd_cnt, 0);
`endif
    cyc();
    mid();
    chk("rs_no_fire", bus.es_valid_o, 0);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
